// File: rtl/sub_32_pipe.sv
// sub_32_pipe: four-stage pipelined 32-bit subtractor, diff = in1 - in2 - bin.
// One byte of the difference is produced per stage, so the borrow chain is
// broken at every register boundary and the longest combinational path is a
// single 8-bit borrow chain. Operands and results move through valid/ready
// handshakes, and a single advance enable moves or freezes the whole pipe.
module sub_32_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff,
    output logic        bout,
    output logic        ovf
);

    // Byte-wide subtract with borrow: bit 8 of the 9-bit result is the borrow-out.
    function automatic logic [8:0] sub_byte(input logic [7:0] x, input logic [7:0] y,
                                            input logic b);
        return {1'b0, x} - {1'b0, y} - {8'd0, b};
    endfunction

    // S0: byte 0 done, bytes 1..3 of the operands still pending.
    logic        s0_valid_q,  s0_valid_d;
    logic [7:0]  s0_diff_q,   s0_diff_d;
    logic        s0_borrow_q, s0_borrow_d;
    logic [31:8] s0_a_q,      s0_a_d;
    logic [31:8] s0_b_q,      s0_b_d;

    // S1: bytes 0..1 done.
    logic        s1_valid_q,  s1_valid_d;
    logic [15:0] s1_diff_q,   s1_diff_d;
    logic        s1_borrow_q, s1_borrow_d;
    logic [31:16] s1_a_q,     s1_a_d;
    logic [31:16] s1_b_q,     s1_b_d;

    // S2: bytes 0..2 done; the top operand byte also carries the sign bits for ovf.
    logic        s2_valid_q,  s2_valid_d;
    logic [23:0] s2_diff_q,   s2_diff_d;
    logic        s2_borrow_q, s2_borrow_d;
    logic [31:24] s2_a_q,     s2_a_d;
    logic [31:24] s2_b_q,     s2_b_d;

    // S3: complete result, drives the outputs directly.
    logic        s3_valid_q,  s3_valid_d;
    logic [31:0] s3_diff_q,   s3_diff_d;
    logic        s3_borrow_q, s3_borrow_d;
    logic        s3_ovf_q,    s3_ovf_d;

    logic [8:0]  s0_res, s1_res, s2_res, s3_res;
    logic        adv;

    // The whole pipe moves whenever the output slot is empty or being drained.
    assign adv       = !s3_valid_q || out_ready;
    assign in_ready  = adv;

    assign out_valid = s3_valid_q;
    assign diff      = s3_diff_q;
    assign bout      = s3_borrow_q;
    assign ovf       = s3_ovf_q;

    // Next-state of every stage: compute one byte and pass the rest along.
    always_comb begin
        // NOTE: every signal below is assigned on every pass with no branches,
        // so this block can never infer a latch.
        s0_res      = sub_byte(in1[7:0], in2[7:0], bin);
        s0_valid_d  = in_valid;
        s0_diff_d   = s0_res[7:0];
        s0_borrow_d = s0_res[8];
        s0_a_d      = in1[31:8];
        s0_b_d      = in2[31:8];

        s1_res      = sub_byte(s0_a_q[15:8], s0_b_q[15:8], s0_borrow_q);
        s1_valid_d  = s0_valid_q;
        s1_diff_d   = {s1_res[7:0], s0_diff_q};
        s1_borrow_d = s1_res[8];
        s1_a_d      = s0_a_q[31:16];
        s1_b_d      = s0_b_q[31:16];

        s2_res      = sub_byte(s1_a_q[23:16], s1_b_q[23:16], s1_borrow_q);
        s2_valid_d  = s1_valid_q;
        s2_diff_d   = {s2_res[7:0], s1_diff_q};
        s2_borrow_d = s2_res[8];
        s2_a_d      = s1_a_q[31:24];
        s2_b_d      = s1_b_q[31:24];

        s3_res      = sub_byte(s2_a_q[31:24], s2_b_q[31:24], s2_borrow_q);
        s3_valid_d  = s2_valid_q;
        s3_diff_d   = {s3_res[7:0], s2_diff_q};
        s3_borrow_d = s3_res[8];
        // Signed overflow: operand signs differ and the result sign differs from in1.
        s3_ovf_d    = (s2_a_q[31] != s2_b_q[31]) && (s3_res[7] != s2_a_q[31]);
    end

    // Pipeline registers: synchronous reset wins, otherwise load all stages on adv.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage samples its predecessor's
        // old value; blocking here would shoot a value through several stages.
        if (rst) begin
            // NOTE: datapath registers are reset as well, not just the valid bits,
            // so diff/bout/ovf read zero straight after reset.
            s0_valid_q  <= 1'b0;
            s0_diff_q   <= '0;
            s0_borrow_q <= 1'b0;
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s1_borrow_q <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_diff_q   <= '0;
            s2_borrow_q <= 1'b0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            s3_valid_q  <= 1'b0;
            s3_diff_q   <= '0;
            s3_borrow_q <= 1'b0;
            s3_ovf_q    <= 1'b0;
        end else if (adv) begin
            s0_valid_q  <= s0_valid_d;
            s0_diff_q   <= s0_diff_d;
            s0_borrow_q <= s0_borrow_d;
            s0_a_q      <= s0_a_d;
            s0_b_q      <= s0_b_d;
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            s1_borrow_q <= s1_borrow_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_diff_q   <= s2_diff_d;
            s2_borrow_q <= s2_borrow_d;
            s2_a_q      <= s2_a_d;
            s2_b_q      <= s2_b_d;
            s3_valid_q  <= s3_valid_d;
            s3_diff_q   <= s3_diff_d;
            s3_borrow_q <= s3_borrow_d;
            s3_ovf_q    <= s3_ovf_d;
        end
    end

endmodule

// File: tb/tb_sub_32_pipe.sv
// tb_sub_32_pipe: scoreboard-driven bench for the four-stage subtractor.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_sub_32_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    always #5 clk = ~clk;

    sub_32_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
    } res_t;

    res_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: exact 33-bit subtraction.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
        logic [32:0] full;
        res_t        r;
        full   = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        r.diff = full[31:0];
        r.bout = full[32];
        r.ovf  = (a[31] != b[31]) && (full[31] != a[31]);
        return r;
    endfunction

    function automatic res_t observed();
        return {diff, bout, ovf};
    endfunction

    // Scoreboard bookkeeping at the sample point: pop on output transfer, push on accept.
    task automatic score(input res_t push_val, output logic popped, output logic have_exp,
                         output res_t exp);
        popped   = out_valid && out_ready;
        have_exp = 1'b0;
        exp      = '0;
        if (popped && exp_q.size() > 0) begin
            exp      = exp_q.pop_front();
            have_exp = 1'b1;
        end
        if (in_valid && in_ready)
            exp_q.push_back(push_val);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in1 = '0; in2 = '0; bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (diff !== 32'h0) begin errors++; $display("FAIL reset_diff: got %h want 00000000", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b want 0", bout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic popped, have_exp, found;
        res_t exp;
        found = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in1 = 32'd5; in2 = 32'd3; bin = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        score(res_t'{32'h0000_0002, 1'b0, 1'b0}, popped, have_exp, exp);
        @(negedge clk);
        in_valid = 1'b0;
        for (int lat = 1; lat <= 20 && !found; lat++) begin
            #1;
            score('0, popped, have_exp, exp);
            if (popped) begin
                found = 1'b1;
                checks++;
                if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
                checks++;
                if (!have_exp || observed() !== exp) begin
                    errors++;
                    $display("FAIL basic_value: got %h/%b/%b want %h/%b/%b", diff, bout, ovf,
                             exp.diff, exp.bout, exp.ovf);
                end
            end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL basic_timeout: got no result want one"); end
    endtask

    task automatic test_borrow_ovf();
        logic [31:0] va[6], vb[6];
        logic        vbin[6];
        res_t        vexp[6];
        logic        popped, have_exp;
        res_t        exp;
        va[0] = 32'h0000_0000; vb[0] = 32'h0000_0001; vbin[0] = 1'b0; vexp[0] = res_t'{32'hFFFF_FFFF, 1'b1, 1'b0};
        va[1] = 32'h0000_0000; vb[1] = 32'h0000_0000; vbin[1] = 1'b1; vexp[1] = res_t'{32'hFFFF_FFFF, 1'b1, 1'b0};
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; vbin[2] = 1'b1; vexp[2] = res_t'{32'hFFFF_FFFF, 1'b1, 1'b0};
        va[3] = 32'h0100_0000; vb[3] = 32'h0000_0001; vbin[3] = 1'b0; vexp[3] = res_t'{32'h00FF_FFFF, 1'b0, 1'b0};
        va[4] = 32'h8000_0000; vb[4] = 32'h0000_0001; vbin[4] = 1'b0; vexp[4] = res_t'{32'h7FFF_FFFF, 1'b0, 1'b1};
        va[5] = 32'h7FFF_FFFF; vb[5] = 32'hFFFF_FFFF; vbin[5] = 1'b0; vexp[5] = res_t'{32'h8000_0000, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in1 = va[i]; in2 = vb[i]; bin = vbin[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec_in_ready[%0d]: got %b want 1", i, in_ready); end
            score(vexp[i], popped, have_exp, exp);
            if (popped) begin
                checks++;
                if (!have_exp || observed() !== exp) begin
                    errors++;
                    $display("FAIL vec_value: got %h/%b/%b want %h/%b/%b", diff, bout, ovf, exp.diff, exp.bout, exp.ovf);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            #1;
            score('0, popped, have_exp, exp);
            if (popped) begin
                checks++;
                if (!have_exp || observed() !== exp) begin
                    errors++;
                    $display("FAIL vec_value: got %h/%b/%b want %h/%b/%b", diff, bout, ovf, exp.diff, exp.bout, exp.ovf);
                end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL vec_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int   sent = 0, recv = 0, stall_left = 0;
        bit   stall_done = 1'b0;
        res_t held = '0;
        logic popped, have_exp;
        res_t exp;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && recv < 8; c++) begin
            if (!stall_done && out_valid) begin
                stall_done = 1'b1;
                stall_left = 5;
                held       = observed();
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < 8);
            in1       = 32'(sent) * 32'h0101_0101;
            in2       = 32'(sent);
            bin       = 1'b0;
            #1;
            if (stall_left > 0) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_stall_handshake: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
                end
                if (stall_left < 5) begin
                    checks++;
                    if (observed() !== held) begin
                        errors++; $display("FAIL bp_stall_stable: got %h want %h", observed(), held);
                    end
                end
            end
            if (in_valid && in_ready) sent++;
            score(model(in1, in2, bin), popped, have_exp, exp);
            if (popped) begin
                recv++;
                checks++;
                if (!have_exp || observed() !== exp) begin
                    errors++;
                    $display("FAIL bp_value: got %h/%b/%b want %h/%b/%b", diff, bout, ovf, exp.diff, exp.bout, exp.ovf);
                end
            end
            if (stall_left > 0) stall_left--;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (recv != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", recv); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pending: got %0d want 0", exp_q.size()); end
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate: got out_valid=%b want 0", out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_bubbles();
        logic hist[14];
        logic popped, have_exp;
        res_t exp;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            hist[c]  = (c < 10) && (c % 2 == 0);
            in_valid = hist[c];
            in1      = $urandom;
            in2      = $urandom;
            bin      = 1'($urandom_range(1));
            #1;
            checks++;
            if (out_valid !== ((c >= 4) ? hist[c-4] : 1'b0)) begin
                errors++; $display("FAIL bubble_pattern[%0d]: got %b want %b", c, out_valid, (c >= 4) ? hist[c-4] : 1'b0);
            end
            score(model(in1, in2, bin), popped, have_exp, exp);
            if (popped) begin
                checks++;
                if (!have_exp || observed() !== exp) begin
                    errors++;
                    $display("FAIL bubble_value: got %h/%b/%b want %h/%b/%b", diff, bout, ovf, exp.diff, exp.bout, exp.ovf);
                end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bubble_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        res_t want;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in1 = 32'h1000_0000 + 32'(c); in2 = 32'h2; bin = 1'b0;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_accept[%0d]: got %b want 1", c, in_ready); end
            @(negedge clk);
        end
        // Operands offered during reset must be dropped: reset wins over the handshake.
        rst = 1'b1; in_valid = 1'b1; in1 = 32'hDEAD_BEEF; in2 = 32'h1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale_pre: got %b want 0", out_valid); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        in_valid = 1'b1; in1 = 32'h0000_0100; in2 = 32'h0000_0001; bin = 1'b1;
        want = res_t'{32'h0000_00FE, 1'b0, 1'b0};
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        checks++; if (observed() !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", observed()); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if (out_valid !== (c == 4)) begin
                errors++; $display("FAIL rst_after_valid[%0d]: got %b want %b", c, out_valid, (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (observed() !== want) begin
                    errors++; $display("FAIL rst_after_value: got %h want %h", observed(), want);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_borrow_ovf();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sub_32_pipe.md
# sub_32_pipe

Four-stage pipelined 32-bit subtractor with borrow-in and borrow-out, the inverse-direction companion to the team's 32-bit adder. It computes `diff = in1 - in2 - bin` (mod 2^32) 8 bits per stage, so the borrow chain is split across register boundaries. Operands enter and results leave through valid/ready handshakes. It sits between an operand-producing datapath stage and a result consumer that may apply backpressure.

## Interface
Parameters: none. Width is fixed at 32 and stage count is fixed at 4.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — operands present on `in1`/`in2`/`bin`.
- `in_ready`  out  1  — block accepts operands this cycle.
- `in1`  in  32  — minuend, unsigned or two's complement.
- `in2`  in  32  — subtrahend.
- `bin`  in  1  — borrow-in.
- `out_valid`  out  1  — result present on `diff`/`bout`/`ovf`.
- `out_ready`  in  1  — consumer accepts the result this cycle.
- `diff`  out  32  — `in1 - in2 - bin`, mod 2^32.
- `bout`  out  1  — unsigned borrow-out: 1 iff `in1 < in2 + bin` (exact, 33-bit compare).
- `ovf`  out  1  — signed overflow: `(in1[31] != in2[31]) && (diff[31] != in1[31])`.

## Operation
- **Pipeline structure**
  - Stages S0..S3. Each holds a valid bit, the partial difference, the running borrow, and the not-yet-processed upper operand bytes plus `in1[31]`/`in2[31]` for `ovf`.
  - Stage k computes byte k: `{borrow_k, diff[8k+7:8k]} = in1_byte - in2_byte - borrow_in`.
  - S0 takes `bin` as its borrow-in. Stage k>0 takes S(k-1)'s registered borrow.
- **Outputs**
  - `diff`, `bout` and `ovf` are driven directly from S3 registers.
  - `bout` is S3's borrow. `ovf` is computed in S3.
  - `out_valid` = S3 valid.
- **Global advance enable**
  - `adv = !out_valid || out_ready`.
  - When `adv`=1, every stage loads from its predecessor, and S0 loads `in_valid` as its valid bit.
  - When `adv`=0, all stage registers hold.
- **Input handshake**
  - `in_ready = adv`, combinational from `out_valid`/`out_ready` only.
  - Transfer occurs when `in_valid && in_ready`.
  - `in_ready` never depends on `in_valid`.
- **Ordering and bubbles**
  - Bubbles are not collapsed. An empty slot advances like a full one.
  - Results emerge in acceptance order. No drops, no duplication.
- **Reset**
  - All stage valid bits clear; `out_valid`=0; `diff`=0; `bout`=0; `ovf`=0.
  - `in_ready`=1 in the first cycle after reset.
  - Reset asserted mid-operation discards every in-flight transaction. No partial result is ever presented.
- **Stall stability**: while `out_valid && !out_ready`, `diff`/`bout`/`ovf` are stable.

## Timing
- **Latency**: operands accepted at rising edge t0 produce `out_valid`=1 with the result after edge t0+3. The result is visible in the cycle following t0+3, provided `adv`=1 at t0+1..t0+3.
- **Stall**: each cycle with `adv`=0 adds exactly one cycle of latency to every in-flight transaction.
- **Throughput**: one transaction per cycle while `out_ready` is held high.
- **Capacity**: at most 4 transactions in flight. When S3 stalls, upstream slots are frozen, not compacted.
- **Simultaneous events**: a consumer pop and a producer push in the same cycle is legal and both complete, because `adv`=1 via `out_ready`.
- **Reset priority**: `rst` has priority over every handshake in the same cycle.
- **Combinational paths**: the longest path is one 8-bit borrow chain plus register setup. No 32-bit combinational chain exists.

## Test plan
- **Basic**: accept `in1`=5, `in2`=3, `bin`=0 at edge t0 with `out_ready`=1 -> `out_valid` rises after t0+3; `diff`=0x00000002, `bout`=0, `ovf`=0.
- **Borrow and wrap**:
  - `0 - 1`, `bin`=0 -> `diff`=0xFFFFFFFF, `bout`=1.
  - `0 - 0`, `bin`=1 -> `diff`=0xFFFFFFFF, `bout`=1.
  - `0xFFFFFFFF - 0xFFFFFFFF`, `bin`=1 -> `diff`=0xFFFFFFFF, `bout`=1.
- **Cross-stage borrow and signed overflow**:
  - `0x01000000 - 1` -> `diff`=0x00FFFFFF, `bout`=0.
  - `0x80000000 - 1` -> `diff`=0x7FFFFFFF, `bout`=0, `ovf`=1.
  - `0x7FFFFFFF - 0xFFFFFFFF` -> `diff`=0x80000000, `bout`=1, `ovf`=1.
- **Backpressure**:
  - Stimulus: stream 8 back-to-back operand pairs (`in1`=i*0x01010101, `in2`=i, `bin`=0, i=0..7). Hold `out_ready`=0 for 5 cycles once the first result appears, then 1.
  - Required: `in_ready`=0 throughout the stall; S3 outputs stable; all 8 results delivered in order with correct values; none lost or duplicated.
- **Bubbles**:
  - Stimulus: toggle `in_valid` every cycle with `out_ready`=1.
  - Required: `out_valid` toggles in the same pattern delayed by 4 cycles; results match in order.
- **Reset mid-flight**:
  - Stimulus: accept 3 transactions, then assert `rst` for 1 cycle.
  - Required: next cycle `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0, `in_ready`=1; no stale result ever appears; a new transaction accepted after reset returns correctly 4 cycles later.
